fpadd_issue_sched: RTL and testbench
====================================

// Module: fpadd_issue_sched
// PURPOSE
//  Shares one pipelined 64-bit FP add unit (fixed latency, no stall input)
//  among NREQ requesters. Round-robin issue, one op per cycle max; tags each op
//  with its requester ID through the pipe. Results are captured into a response
//  FIFO drained by a valid/ready consumer.
//  Credit scheme: an op is only issued if its result is guaranteed a FIFO slot.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  IDW     2   requester ID width, clog2(NREQ)
//  LAT     2   add-unit latency, issue cycle to result cycle (1..4)
//  DEPTH   4   response FIFO entries (>= LAT recommended; 2..16)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active high
//  req_valid  in   NREQ     per-requester op valid
//  req_ready  out  NREQ     per-requester accept (one-hot or zero)
//  req_a      in   NREQ*64  operand A, requester i at [64*i+:64]
//  req_b      in   NREQ*64  operand B
//  req_rnd    in   NREQ     rounding control bit, passed to unit
//  req_pookm  in   NREQ     hidden-bit control for B, passed to unit
//  fpu_a      out  64       operand A to add unit
//  fpu_b      out  64       operand B to add unit
//  fpu_rnd    out  1        rnd to add unit
//  fpu_pookm  out  1        pookm to add unit
//  fpu_res    in   64       add-unit result, valid LAT cycles after issue
//  rsp_valid  out  1        response FIFO non-empty
//  rsp_ready  in   1        consumer accepts head
//  rsp_data   out  64       head result
//  rsp_id     out  IDW      requester ID of head result
// BEHAVIOUR
//  - Reset (async, rst=1): rr_ptr=0, pipe tag valids=0, FIFO rd/wr ptrs and count=0,
//    rsp_valid=0, req_ready=0. Ops in flight at reset are discarded, never delivered.
//  - credit_ok = (inflight + fifo_count + 1) <= DEPTH. inflight = number of set pipe
//    valid bits. Count ops leaving the pipe this cycle as still occupying space.
//    Count a FIFO pop this cycle as freeing space.
//  - Arbitration (comb): grant = first i with req_valid[i], scanning rr_ptr,
//    rr_ptr+1, ... mod NREQ. req_ready[grant]=credit_ok; all others 0.
//  - Issue = |req_valid & credit_ok. On issue: fpu_* driven from granted requester
//    that cycle.
//    Tag {1,grant} enters pipe stage 0. rr_ptr <= (grant+1) mod NREQ.
//    rr_ptr holds when there is no issue.
//  - No issue: fpu_a/fpu_b/fpu_rnd/fpu_pookm driven 0; stage-0 valid=0.
//  - Tag pipe: LAT-deep shift register, advances every cycle (unit never stalls).
//    When the stage LAT-1 tag is valid, fpu_res and the tag ID are pushed into the FIFO.
//  - FIFO: pop when rsp_valid&rsp_ready. Push and pop in the same cycle are both
//    performed, including when the FIFO is full. The credit rule guarantees a push
//    never finds the FIFO full with no pop.
//  - Overflow is unreachable. The bench asserts it (push & full & !pop = error).
//  - Ordering: responses leave in issue order. Throughput 1 op/cycle when
//    DEPTH >= LAT+1 and the consumer is always ready.
//  - rsp_data/rsp_id are registered FIFO outputs. They are stable while
//    rsp_valid & !rsp_ready.
// CONFIGURATION
//  FPADD_SCHED_PERF_EN defined:
//   - Adds outputs perf_issue[31:0] (issued ops) and perf_stall[31:0].
//   - perf_stall counts cycles with |req_valid & !credit_ok.
//   - Both counters reset to 0, wrap at 2^32, and count every cycle they qualify.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING  (bench stub unit: LAT-deep pipe returning fpu_a+fpu_b, integer)
//  1. Single op: rst then req0 A=64'h10 B=64'h20 ->
//     issued the cycle credit_ok is high;
//     rsp_valid LAT+1 cycles later with rsp_data=64'h30, rsp_id=0.
//  2. All 4 requesters valid, rsp_ready=1: grants go 0,1,2,3,0 on consecutive
//     cycles; responses come back in the same ID order.
//  3. rsp_ready=0, req1 streaming: exactly DEPTH=4 ops issued, then req_ready=0.
//     perf_stall increments each stall cycle.
//     Raise rsp_ready: 4 results drain and issue resumes.
//  4. FIFO full with a push and pop in the same cycle: count stays 4, no data lost.
//     Result order matches issue order.
//  5. Assert rst with 2 ops in flight: rsp_valid=0 immediately.
//     Neither result ever appears after release; rr_ptr restarts at 0.
//  6. req2 only, then req0+req2 together: grant goes to req0
//     (rr_ptr=3 wraps to 0); the next cycle grants req2.

Source files
------------

// File: rtl/fpadd_issue_sched.sv
// Round-robin issue scheduler sharing one fixed-latency FP add unit, with credit-gated response FIFO.
// Optional perf counters (perf_issue, perf_stall) are enabled by defining FPADD_SCHED_PERF_EN.
module fpadd_issue_sched #(
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*64-1:0]   req_a,
   input  logic [NREQ*64-1:0]   req_b,
   input  logic [NREQ-1:0]      req_rnd,
   input  logic [NREQ-1:0]      req_pookm,
   output logic [63:0]          fpu_a,
   output logic [63:0]          fpu_b,
   output logic                 fpu_rnd,
   output logic                 fpu_pookm,
   input  logic [63:0]          fpu_res,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [63:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id
`ifdef FPADD_SCHED_PERF_EN
   ,
   output logic [31:0]          perf_issue,
   output logic [31:0]          perf_stall
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + LAT + 2);

   logic [IDW-1:0] rrPtr_q, rrPtr_d;
   logic [IDW-1:0] grant;
   logic           anyValid, creditOk, issue, push, pop;
   logic [CW-1:0]  inflight;

   logic [LAT-1:0] tagValid_q;
   logic [IDW-1:0] tagId_q [LAT];

   logic [63:0]    fifoData_q [DEPTH];
   logic [IDW-1:0] fifoId_q   [DEPTH];
   logic [PW-1:0]  rdPtr_q, wrPtr_q;
   logic [CW-1:0]  count_q;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int k = 0; k < LAT; k++) begin
         inflight = inflight + CW'(tagValid_q[k]);
      end
   end

   // Results still in the pipe hold a slot; a pop this cycle frees one.
   assign pop      = rsp_valid & rsp_ready;
   assign push     = tagValid_q[LAT-1];
   assign creditOk = (inflight + count_q + CW'(1) - CW'(pop)) <= CW'(DEPTH);
   assign anyValid = |req_valid;
   assign issue    = anyValid & creditOk & ~rst;

   always_comb begin : arbComb
      int idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rrPtr_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            grant = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      fpu_a     = '0;
      fpu_b     = '0;
      fpu_rnd   = 1'b0;
      fpu_pookm = 1'b0;
      rrPtr_d   = rrPtr_q;
      if (issue) begin
         req_ready = NREQ'(1) << grant;
         fpu_a     = req_a[64*grant +: 64];
         fpu_b     = req_b[64*grant +: 64];
         fpu_rnd   = req_rnd[grant];
         fpu_pookm = req_pookm[grant];
         rrPtr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrPtr_q    <= '0;
         tagValid_q <= '0;
         for (int k = 0; k < LAT; k++) tagId_q[k] <= '0;
      end else begin
         rrPtr_q       <= rrPtr_d;
         tagValid_q[0] <= issue;
         tagId_q[0]    <= grant;
         for (int k = 1; k < LAT; k++) begin
            tagValid_q[k] <= tagValid_q[k-1];
            tagId_q[k]    <= tagId_q[k-1];
         end
      end
   end

   // When full, a simultaneous push overwrites the slot being popped.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoData_q[wrPtr_q] <= fpu_res;
         fifoId_q[wrPtr_q]   <= tagId_q[LAT-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= nextPtr(wrPtr_q);
         if (pop)  rdPtr_q <= nextPtr(rdPtr_q);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign rsp_valid = (count_q != '0);
   assign rsp_data  = fifoData_q[rdPtr_q];
   assign rsp_id    = fifoId_q[rdPtr_q];

`ifdef FPADD_SCHED_PERF_EN
   logic [31:0] perfIssue_q, perfStall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfIssue_q <= '0;
         perfStall_q <= '0;
      end else begin
         if (issue)                 perfIssue_q <= perfIssue_q + 32'd1;
         if (anyValid && !creditOk) perfStall_q <= perfStall_q + 32'd1;
      end
   end

   assign perf_issue = perfIssue_q;
   assign perf_stall = perfStall_q;
`endif

endmodule

// File: tb/tb_fpadd_issue_sched.sv
// Scoreboard bench for fpadd_issue_sched with an integer-add stub standing in for the FP unit.
// Perf counter checks are compiled in when FPADD_SCHED_PERF_EN is defined.
module tb_fpadd_issue_sched;

   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*64-1:0]  req_a = '0;
   logic [NREQ*64-1:0]  req_b = '0;
   logic [NREQ-1:0]     req_rnd = '0;
   logic [NREQ-1:0]     req_pookm = '0;
   logic [63:0]         fpu_a, fpu_b, fpu_res;
   logic                fpu_rnd, fpu_pookm;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [63:0]         rsp_data;
   logic [IDW-1:0]      rsp_id;
`ifdef FPADD_SCHED_PERF_EN
   logic [31:0]         perf_issue, perf_stall;
`endif

   typedef struct {
      logic [63:0]    data;
      logic [IDW-1:0] id;
   } expT;

   expT         sbq[$];
   expT         popped;
   int          grantLog[$];
   int          vecCount  = 0;
   int          missCount = 0;
   logic [63:0] stubPipe [LAT];

   fpadd_issue_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_rnd   (req_rnd),
      .req_pookm (req_pookm),
      .fpu_a     (fpu_a),
      .fpu_b     (fpu_b),
      .fpu_rnd   (fpu_rnd),
      .fpu_pookm (fpu_pookm),
      .fpu_res   (fpu_res),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef FPADD_SCHED_PERF_EN
      ,
      .perf_issue(perf_issue),
      .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in add unit: fixed LAT-deep pipe returning a+b.
   always @(posedge clk) begin
      stubPipe[0] <= fpu_a + fpu_b;
      for (int k = 1; k < LAT; k++) stubPipe[k] <= stubPipe[k-1];
   end
   assign fpu_res = stubPipe[LAT-1];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor on the falling edge: retire responses, then log this cycle's issue.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && sbq.size() == 0) begin
            checkOutput("phantom rsp_valid", 64'(rsp_valid), 64'd0);
         end else if (rsp_valid && rsp_ready) begin
            popped = sbq.pop_front();
            checkOutput("rsp_data", rsp_data, popped.data);
            checkOutput("rsp_id", 64'(rsp_id), 64'(popped.id));
         end
         checkOutput("req_ready onehot0", 64'($onehot0(req_ready)), 64'd1);
         checkOutput("req_ready without valid", 64'(req_ready & ~req_valid), 64'd0);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               checkOutput("fpu_a", fpu_a, req_a[64*i +: 64]);
               checkOutput("fpu_b", fpu_b, req_b[64*i +: 64]);
               checkOutput("fpu_rnd", 64'(fpu_rnd), 64'(req_rnd[i]));
               checkOutput("fpu_pookm", 64'(fpu_pookm), 64'(req_pookm[i]));
               sbq.push_back('{data: req_a[64*i +: 64] + req_b[64*i +: 64], id: IDW'(i)});
               grantLog.push_back(i);
            end
         end
         checkOutput("occupancy within DEPTH", 64'(sbq.size() <= DEPTH), 64'd1);
      end
   end

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid);
      req_valid = valid;
      for (int i = 0; i < NREQ; i++) begin
         req_a[64*i +: 64] = {$urandom, $urandom};
         req_b[64*i +: 64] = {$urandom, $urandom};
      end
      req_rnd   = NREQ'($urandom);
      req_pookm = NREQ'($urandom);
   endtask

   task automatic driveCycle(input logic [NREQ-1:0] valid);
      applyStimulus(valid);
      stepCycles(1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while ((sbq.size() != 0 || rsp_valid) && n < 60) begin
         stepCycles(1);
         n++;
      end
      checkOutput("drain", 64'(sbq.size()), 64'd0);
   endtask

   task automatic pulseReset();
      req_valid = '0;
      rst = 1'b1;
      sbq.delete();
      stepCycles(2);
      rst = 1'b0;
   endtask

   initial begin : stimulus
      int seq2[5];
      int seq6[3];
      logic [63:0] held;
`ifdef FPADD_SCHED_PERF_EN
      logic [31:0] stall0, issue0;
`endif
      seq2 = '{0, 1, 2, 3, 0};
      seq6 = '{2, 0, 2};

      // Reset state with every requester asking.
      applyStimulus('1);
      #1;
      checkOutput("reset req_ready", 64'(req_ready), 64'd0);
      checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
      stepCycles(2);
      req_valid = '0;
      rst = 1'b0;
      stepCycles(1);
      checkOutput("idle fpu_a", fpu_a, 64'd0);
      checkOutput("idle fpu_b", fpu_b, 64'd0);

      // Single op through requester 0.
      rsp_ready = 1'b1;
      applyStimulus(4'b0001);
      req_a[63:0] = 64'h10;
      req_b[63:0] = 64'h20;
      #1;
      checkOutput("t1 req_ready", 64'(req_ready), 64'd1);
      stepCycles(1);
      req_valid = '0;
      checkOutput("t1 rsp_valid +1", 64'(rsp_valid), 64'd0);
      stepCycles(1);
      checkOutput("t1 rsp_valid +2", 64'(rsp_valid), 64'd0);
      stepCycles(1);
      checkOutput("t1 rsp_valid +3", 64'(rsp_valid), 64'd1);
      checkOutput("t1 rsp_data", rsp_data, 64'h30);
      checkOutput("t1 rsp_id", 64'(rsp_id), 64'd0);
      drain();

      // All requesters valid: rotation 0,1,2,3,0 from a fresh pointer.
      pulseReset();
      grantLog.delete();
      for (int c = 0; c < 5; c++) driveCycle('1);
      drain();
      checkOutput("t2 grant count", 64'(grantLog.size()), 64'd5);
      for (int k = 0; k < 5 && k < grantLog.size(); k++)
         checkOutput($sformatf("t2 grant%0d", k), 64'(grantLog[k]), 64'(seq2[k]));

      // Consumer stalled: only DEPTH ops may be accepted.
      rsp_ready = 1'b0;
      grantLog.delete();
`ifdef FPADD_SCHED_PERF_EN
      stall0 = perf_stall;
      issue0 = perf_issue;
`endif
      for (int c = 0; c < 8; c++) driveCycle(4'b0010);
      checkOutput("t3 issued while stalled", 64'(grantLog.size()), 64'(DEPTH));
      checkOutput("t3 req_ready blocked", 64'(req_ready), 64'd0);
      checkOutput("t3 rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t3 head data", rsp_data, sbq[0].data);
`ifdef FPADD_SCHED_PERF_EN
      checkOutput("t3 perf_stall delta", 64'(perf_stall - stall0), 64'd4);
      checkOutput("t3 perf_issue delta", 64'(perf_issue - issue0), 64'd4);
`endif
      held = rsp_data;
      stepCycles(1);
      checkOutput("t3 head stable", rsp_data, held);
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) driveCycle(4'b0010);
      checkOutput("t3 issue resumed", 64'(grantLog.size() > DEPTH), 64'd1);
      drain();

      // Full FIFO then simultaneous push/pop with two requesters alternating.
      rsp_ready = 1'b0;
      grantLog.delete();
      for (int c = 0; c < 6; c++) driveCycle(4'b1001);
      rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         driveCycle(4'b1001);
         checkOutput("t4 rsp_valid held", 64'(rsp_valid), 64'd1);
      end
      drain();
      for (int k = 0; k < grantLog.size(); k++)
         checkOutput($sformatf("t4 grant%0d", k), 64'(grantLog[k]), (k % 2 == 0) ? 64'd3 : 64'd0);

      // Reset with two ops in flight: they must vanish.
      applyStimulus(4'b0100);
      stepCycles(2);
      req_valid = '0;
      rst = 1'b1;
      sbq.delete();
      #1;
      checkOutput("t5 rsp_valid in reset", 64'(rsp_valid), 64'd0);
      stepCycles(2);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         stepCycles(1);
         checkOutput("t5 no stale rsp", 64'(rsp_valid), 64'd0);
      end
      grantLog.delete();
      driveCycle('1);
      req_valid = '0;
      checkOutput("t5 grant after reset", 64'(grantLog.size() == 1 ? grantLog[0] : -1), 64'd0);
      drain();

      // Pointer wrap: req2 alone, then req0+req2.
      pulseReset();
      grantLog.delete();
      driveCycle(4'b0100);
      driveCycle(4'b0101);
      driveCycle(4'b0101);
      drain();
      checkOutput("t6 grant count", 64'(grantLog.size()), 64'd3);
      for (int k = 0; k < 3 && k < grantLog.size(); k++)
         checkOutput($sformatf("t6 grant%0d", k), 64'(grantLog[k]), 64'(seq6[k]));

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
